axi4_sim_mem: RTL and testbench

//  Behavioural AXI4 slave memory on the FPGA side of the chiplink bridge. It serves the bridge's
//  mem_axi4_0 master port and backs off-chip DRAM in SoC simulation.

---
 rtl/axi4_sim_mem_pkg.sv | 24 ++
 rtl/axi4_sim_mem_if.sv | 55 +++++
 rtl/axi4_sim_mem_addr_next.sv | 30 +++
 rtl/axi4_sim_mem.sv | 162 ++++++++++++++++
 tb/tb_axi4_sim_mem.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_sim_mem_pkg.sv
// Shared types for the behavioural AXI4 slave memory: burst/response codes and FSM states.
package axi4_sim_mem_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi4_sim_mem_if.sv
// AXI4 bus between the chiplink mem_axi4_0 master and the simulation memory slave.
interface axi4_sim_mem_if #(
    parameter int ADDR_W = 31,
    parameter int ID_W   = 4
);
    logic              awready;
    logic              awvalid;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wready;
    logic              wvalid;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;

    logic              bready;
    logic              bvalid;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    logic              arready;
    logic              arvalid;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rready;
    logic              rvalid;
    logic [ID_W-1:0]   rid;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        input  awready, output awvalid, awid, awaddr, awlen, awsize, awburst,
        input  wready,  output wvalid, wdata, wstrb, wlast,
        output bready,  input  bvalid, bid, bresp,
        input  arready, output arvalid, arid, araddr, arlen, arsize, arburst,
        output rready,  input  rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        output awready, input  awvalid, awid, awaddr, awlen, awsize, awburst,
        output wready,  input  wvalid, wdata, wstrb, wlast,
        input  bready,  output bvalid, bid, bresp,
        output arready, input  arvalid, arid, araddr, arlen, arsize, arburst,
        input  rready,  output rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi4_sim_mem_addr_next.sv
// Next beat address for an AXI burst (FIXED, INCR/reserved, WRAP).
module axi_burst_addr_next
    import axi4_sim_mem_pkg::*;
#(
    parameter int ADDR_W = 31
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [7:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] addr_next
);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;

    assign step      = ADDR_W'(1) << size;
    assign incr      = addr + step;
    // Wrap region is (len+1)<<size bytes, naturally aligned; only the low bits move.
    assign wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);

    always_comb begin
        addr_next = incr;
        if (burst == BURST_FIXED) begin
            addr_next = addr;
        end else if (burst == BURST_WRAP) begin
            addr_next = (addr & ~wrap_mask) | (incr & wrap_mask);
        end
    end
endmodule

// File: rtl/axi4_sim_mem.sv
// Behavioural AXI4 slave memory with independent single-outstanding read/write engines.
// Define AXI_MEM_BOUNDS_CHECK_EN to answer SLVERR for addresses beyond the array instead of aliasing.
module axi4_sim_mem
    import axi4_sim_mem_pkg::*;
#(
    parameter int ADDR_W    = 31,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MEM_WORDS = 65536
) (
    input  logic          clock,
    input  logic          reset,
    axi4_sim_mem_if.slave io_axi4_0
);
    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int STRB_W = DATA_W / 8;

    w_state_e          w_state, w_state_nxt;
    r_state_e          r_state, r_state_nxt;
    logic [ID_W-1:0]   w_id, r_id;
    logic [ADDR_W-1:0] w_addr, w_addr_nxt, r_addr, r_addr_nxt;
    logic [7:0]        w_len, w_beat, r_len, r_beat;
    logic [2:0]        w_size, r_size;
    logic [1:0]        w_burst, r_burst;
    logic              w_err, w_oob, r_oob, w_fire, r_fire;
    logic [IDX_W-1:0]  w_idx, r_idx;
    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic              unused_wlast;

    assign unused_wlast = io_axi4_0.wlast;
    assign w_idx  = w_addr[IDX_W+2:3];
    assign r_idx  = r_addr[IDX_W+2:3];
    assign w_fire = (w_state == W_DATA) && io_axi4_0.wvalid;
    assign r_fire = (r_state == R_DATA) && io_axi4_0.rready;

`ifdef AXI_MEM_BOUNDS_CHECK_EN
    assign w_oob = (w_addr >> (IDX_W + 3)) != '0;
    assign r_oob = (r_addr >> (IDX_W + 3)) != '0;
`else
    assign w_oob = 1'b0;
    assign r_oob = 1'b0;
`endif

    axi_burst_addr_next #(.ADDR_W(ADDR_W)) u_w_next (
        .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .addr_next(w_addr_nxt)
    );
    axi_burst_addr_next #(.ADDR_W(ADDR_W)) u_r_next (
        .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .addr_next(r_addr_nxt)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt       = w_state;
        io_axi4_0.awready = 1'b0;
        io_axi4_0.wready  = 1'b0;
        io_axi4_0.bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                io_axi4_0.awready = 1'b1;
                if (io_axi4_0.awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                io_axi4_0.wready = 1'b1;
                if (io_axi4_0.wvalid && (w_beat == w_len)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                io_axi4_0.bvalid = 1'b1;
                if (io_axi4_0.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if ((w_state == W_IDLE) && io_axi4_0.awvalid) begin
            w_id    <= io_axi4_0.awid;
            w_addr  <= io_axi4_0.awaddr;
            w_len   <= io_axi4_0.awlen;
            w_size  <= io_axi4_0.awsize;
            w_burst <= io_axi4_0.awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (w_fire) begin
            w_addr <= w_addr_nxt;
            w_beat <= w_beat + 8'd1;
            if (w_oob) w_err <= 1'b1;
        end
    end

    // Contents are deliberately left out of reset so DRAM images survive a reset.
    always_ff @(posedge clock) begin
        if (w_fire && !w_oob) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (io_axi4_0.wstrb[b]) mem[w_idx][8*b +: 8] <= io_axi4_0.wdata[8*b +: 8];
            end
        end
    end

    assign io_axi4_0.bid   = w_id;
    assign io_axi4_0.bresp = w_err ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt       = r_state;
        io_axi4_0.arready = 1'b0;
        io_axi4_0.rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                io_axi4_0.arready = 1'b1;
                if (io_axi4_0.arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                io_axi4_0.rvalid = 1'b1;
                if (io_axi4_0.rready && (r_beat == r_len)) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_beat  <= '0;
        end else if ((r_state == R_IDLE) && io_axi4_0.arvalid) begin
            r_id    <= io_axi4_0.arid;
            r_addr  <= io_axi4_0.araddr;
            r_len   <= io_axi4_0.arlen;
            r_size  <= io_axi4_0.arsize;
            r_burst <= io_axi4_0.arburst;
            r_beat  <= '0;
        end else if (r_fire) begin
            r_addr <= r_addr_nxt;
            r_beat <= r_beat + 8'd1;
        end
    end

    // Read data is combinational from the registered address, so a same-edge write is not seen.
    assign io_axi4_0.rid   = r_id;
    assign io_axi4_0.rlast = (r_state == R_DATA) && (r_beat == r_len);
    assign io_axi4_0.rdata = r_oob ? '0 : mem[r_idx];
    assign io_axi4_0.rresp = ((r_state == R_DATA) && r_oob) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_axi4_sim_mem.sv
// Self-checking bench for axi4_sim_mem: vector table, directed corner sequences and random bursts
// checked against a byte-level memory model with arithmetic burst address generation.
module tb_axi4_sim_mem;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    axi4_sim_mem_if #(.ADDR_W(31), .ID_W(4)) bus ();

    axi4_sim_mem #(.ADDR_W(31), .DATA_W(64), .ID_W(4), .MEM_WORDS(65536)) dut (
        .clock(clk), .reset(rst), .io_axi4_0(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] model [int];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] rd_data [256];
    logic [1:0]  rd_resp [256];
    logic        rd_last [256];
    logic [3:0]  rd_id [256];
    int          rd_cyc [256];
    int          ar_c;

    typedef struct {
        logic [30:0] addr;
        logic [63:0] pre;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp;
    } vec_t;
    vec_t vt [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [30:0] beat_addr(logic [30:0] a, logic [2:0] size, logic [7:0] len,
                                              logic [1:0] burst, int i);
        longint unsigned step, region, base, av;
        step   = 64'd1 << size;
        region = (longint'(len) + 1) * step;
        av     = longint'(a);
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            base = av - (av % region);
            return 31'(base + ((av - base + longint'(i) * step) % region));
        end
        return 31'(av + longint'(i) * step);
    endfunction

    function automatic int widx(logic [30:0] a);
        return int'((a >> 3) & 31'hFFFF);
    endfunction

    function automatic bit oob(logic [30:0] a);
`ifdef AXI_MEM_BOUNDS_CHECK_EN
        return (a >> 19) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        int n;
        bit err_any;
        logic [30:0] a;
        logic [63:0] m;
        err_any = 1'b0;
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr;
        bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_ready_wait", 64'(bus.awready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0) @(negedge clk);
            bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == int'(len));
            n = 0;
            while (!bus.wready && n < 50) begin @(negedge clk); n++; end
            chk("w_ready_wait", 64'(bus.wready), 64'd1);
            @(posedge clk);
            a = beat_addr(addr, size, len, burst, i);
            if (oob(a)) begin
                err_any = 1'b1;
            end else begin
                m = model.exists(widx(a)) ? model[widx(a)] : 64'h0;
                for (int b = 0; b < 8; b++) if (ws[i][b]) m[8*b +: 8] = wd[i][8*b +: 8];
                model[widx(a)] = m;
            end
        end
        @(negedge clk);
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.bready = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
        chk("b_valid_wait", 64'(bus.bvalid), 64'd1);
        chk("bid", 64'(bus.bid), 64'(id));
        chk("bresp", 64'(bus.bresp), err_any ? 64'd2 : 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    // Collects len+1 beats into rd_*; hold_beat>=0 forces rready low for 5 cycles at that beat.
    task automatic axi_read(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int stall_pct, input int hold_beat);
        int n, got, hold;
        bit prev_stall;
        logic [63:0] pd;
        logic [1:0]  pr;
        logic        pl;
        got = 0; hold = 0; prev_stall = 1'b0; pd = '0; pr = '0; pl = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr;
        bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_ready_wait", 64'(bus.arready), 64'd1);
        ar_c = cyc;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        n = 0;
        while (got <= int'(len) && n < 3000) begin
            if (got == hold_beat && hold < 5) begin
                bus.rready = 1'b0;
                hold++;
            end else begin
                bus.rready = ($urandom_range(0, 99) >= stall_pct);
            end
            if (prev_stall) begin
                chk("r_hold_valid", 64'(bus.rvalid), 64'd1);
                chk("r_hold_data", bus.rdata, pd);
                chk("r_hold_resp", 64'(bus.rresp), 64'(pr));
                chk("r_hold_last", 64'(bus.rlast), 64'(pl));
            end
            prev_stall = bus.rvalid && !bus.rready;
            pd = bus.rdata; pr = bus.rresp; pl = bus.rlast;
            if (bus.rvalid && bus.rready) begin
                rd_data[got] = bus.rdata; rd_resp[got] = bus.rresp;
                rd_last[got] = bus.rlast; rd_id[got] = bus.rid; rd_cyc[got] = cyc;
                got++;
            end
            @(negedge clk);
            n++;
        end
        bus.rready = 1'b0;
        chk("r_beats_seen", 64'(got), 64'(int'(len) + 1));
        chk("r_idle_after", 64'(bus.rvalid), 64'd0);
    endtask

    task automatic chk_model(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        logic [30:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = beat_addr(addr, size, len, burst, i);
            if (oob(a)) begin
                chk("rd_oob_data", rd_data[i], 64'h0);
                chk("rd_oob_resp", 64'(rd_resp[i]), 64'd2);
            end else if (model.exists(widx(a))) begin
                chk("rd_model_data", rd_data[i], model[widx(a)]);
                chk("rd_model_resp", 64'(rd_resp[i]), 64'd0);
            end
            chk("rd_last", 64'(rd_last[i]), 64'(i == int'(len)));
            chk("rd_id", 64'(rd_id[i]), 64'(id));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] exp_wrap [4];
        logic [30:0] ra;
        logic [7:0]  rl;
        logic [2:0]  rs;
        logic [1:0]  rb;

        vt[0] = '{31'h100, 64'h0, 64'h1122334455667788, 8'hFF, 64'h1122334455667788};
        vt[1] = '{31'h400, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0000_0000_FFFF_FFFF};
        vt[2] = '{31'h408, 64'h0123_4567_89AB_CDEF, 64'h0, 8'hF0, 64'h0000_0000_89AB_CDEF};
        vt[3] = '{31'h410, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_A5A5_A5A5_A5A5, 8'h81, 64'hA5FF_FFFF_FFFF_FFA5};
        vt[4] = '{31'h41D, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 64'h5555_5555_5555_5555};
        exp_wrap[0] = 64'h310; exp_wrap[1] = 64'h318; exp_wrap[2] = 64'h300; exp_wrap[3] = 64'h308;

        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        #12;
        chk("rst_awready", 64'(bus.awready), 64'd1);
        chk("rst_arready", 64'(bus.arready), 64'd1);
        chk("rst_wready", 64'(bus.wready), 64'd0);
        chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("rst_rlast", 64'(bus.rlast), 64'd0);
        chk("rst_ids", 64'({bus.bid, bus.rid}), 64'd0);
        chk("rst_resps", 64'({bus.bresp, bus.rresp}), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // 256-beat fill of words 0..255, read back as one 256-beat burst
        for (int i = 0; i < 256; i++) begin wd[i] = 64'hC0DE_0000_0000_0000 | 64'(i); ws[i] = 8'hFF; end
        axi_write(4'd1, 31'h0, 8'd255, 3'd3, 2'b01);
        axi_read(4'd2, 31'h0, 8'd255, 3'd3, 2'b01, 0, -1);
        chk_model(4'd2, 31'h0, 8'd255, 3'd3, 2'b01);
        chk("fill_last_word", rd_data[255], 64'hC0DE_0000_0000_00FF);

        // single-beat byte-enable vectors
        for (int i = 0; i < 5; i++) begin
            wd[0] = vt[i].pre; ws[0] = 8'hFF;
            axi_write(4'(i), vt[i].addr, 8'd0, 3'd3, 2'b01);
            wd[0] = vt[i].data; ws[0] = vt[i].strb;
            axi_write(4'(i + 8), vt[i].addr, 8'd0, 3'd3, 2'b01);
            axi_read(4'(i + 3), vt[i].addr, 8'd0, 3'd3, 2'b01, 0, -1);
            chk("vec_rdata", rd_data[0], vt[i].exp);
            chk("vec_rlast", 64'(rd_last[0]), 64'd1);
            chk("vec_rid", 64'(rd_id[0]), 64'(4'(i + 3)));
        end

        // INCR len=3, back-to-back read beats
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; end
        axi_write(4'd7, 31'h200, 8'd3, 3'd3, 2'b01);
        axi_read(4'd9, 31'h200, 8'd3, 3'd3, 2'b01, 0, -1);
        for (int i = 0; i < 4; i++) begin
            chk("incr_data", rd_data[i], 64'hA0 + 64'(i));
            chk("incr_last", 64'(rd_last[i]), 64'(i == 3));
            chk("incr_cycle", 64'(rd_cyc[i]), 64'(ar_c + 1 + i));
        end

        // WRAP len=3 size=3 starting mid-region
        for (int i = 0; i < 4; i++) begin wd[i] = 64'h300 + 64'(8 * i); ws[i] = 8'hFF; end
        axi_write(4'd4, 31'h300, 8'd3, 3'd3, 2'b01);
        axi_read(4'd6, 31'h310, 8'd3, 3'd3, 2'b10, 0, -1);
        for (int i = 0; i < 4; i++) chk("wrap_data", rd_data[i], exp_wrap[i]);

        // rready low for 5 cycles mid-burst
        axi_read(4'd10, 31'h40, 8'd7, 3'd3, 2'b01, 0, 2);
        chk_model(4'd10, 31'h40, 8'd7, 3'd3, 2'b01);

        // reset in the middle of a read burst
        @(negedge clk);
        bus.arvalid = 1'b1; bus.arid = 4'd5; bus.araddr = 31'h200;
        bus.arlen = 8'd3; bus.arsize = 3'd3; bus.arburst = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_rvalid", 64'(bus.rvalid), 64'd1);
        bus.rready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_arready", 64'(bus.arready), 64'd1);
        chk("midrst_rvalid", 64'(bus.rvalid), 64'd0);
        chk("midrst_rlast", 64'(bus.rlast), 64'd0);
        chk("midrst_awready", 64'(bus.awready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.rready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("postrst_no_r", 64'(bus.rvalid), 64'd0);
        end
        bus.rready = 1'b0;
        axi_read(4'd11, 31'h100, 8'd0, 3'd3, 2'b01, 0, -1);
        chk("retained", rd_data[0], 64'h1122334455667788);

        // address just beyond the array
        wd[0] = 64'hDEAD_BEEF_0BAD_F00D; ws[0] = 8'hFF;
        axi_write(4'd12, 31'h0, 8'd0, 3'd3, 2'b01);
        axi_read(4'd13, 31'h80000, 8'd0, 3'd3, 2'b01, 0, -1);
`ifdef AXI_MEM_BOUNDS_CHECK_EN
        chk("oob_rdata", rd_data[0], 64'h0);
        chk("oob_rresp", 64'(rd_resp[0]), 64'd2);
`else
        chk("alias_rdata", rd_data[0], 64'hDEAD_BEEF_0BAD_F00D);
        chk("alias_rresp", 64'(rd_resp[0]), 64'd0);
`endif

        // random bursts against the model
        for (int t = 0; t < 30; t++) begin
            rb = 2'($urandom_range(0, 3));
            rs = 3'($urandom_range(0, 3));
            if (rb == 2'b10) begin
                case ($urandom_range(0, 3))
                    0: rl = 8'd1;
                    1: rl = 8'd3;
                    2: rl = 8'd7;
                    default: rl = 8'd15;
                endcase
            end else begin
                rl = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 15));
            end
            ra = 31'($urandom_range(0, 11'h7FF));
            if ($urandom_range(0, 3) == 0) ra[30:19] = 12'($urandom_range(1, 4095));
            for (int i = 0; i <= int'(rl); i++) begin
                wd[i] = {$urandom, $urandom};
                ws[i] = 8'($urandom);
            end
            axi_write(4'($urandom), ra, rl, rs, rb);
            axi_read(4'(t), ra, rl, rs, rb, 30, -1);
            chk_model(4'(t), ra, rl, rs, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
